// File: rtl/inst_fetch_assembler_if.sv
// inst_fetch_assembler_if: memory port, redirect and decoder handshake of the fetch stage.
interface inst_fetch_assembler_if;
  logic [31:0] mem_addr;
  logic [7:0]  mem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  modport master (
    output mem_addr, instr_valid, instr, instr_pc,
    input  mem_data, redirect_valid, redirect_pc, instr_ready
  );
  modport slave (
    input  mem_addr, instr_valid, instr, instr_pc,
    output mem_data, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/inst_fetch_assembler.sv
// inst_fetch_assembler: issues four byte reads, packs them little-endian into one
// instruction and hands it to the decoder; owns the PC (advance, wrap, redirect).
module inst_fetch_assembler #(
  parameter int MEM_BYTES = 32,
  parameter int RESET_PC  = 0
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  inst_fetch_assembler_if.master bus
);
  localparam int AW = $clog2(MEM_BYTES);
  typedef enum logic {FETCH, HOLD} state_t;
  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [2:0]    issue_idx_q;
  logic          cap_en_q;
  logic [1:0]    cap_idx_q;
  logic [31:0]   instr_q;
  logic [AW-1:0] offset;
  logic          unused_redirect_hi;
  // issue_idx saturates the address at byte 3 once all four reads are out
  assign offset             = issue_idx_q[2] ? AW'(3) : AW'(issue_idx_q[1:0]);
  assign bus.mem_addr       = 32'(pc_q + offset);
  assign bus.instr_valid    = state_q == HOLD && !bus.redirect_valid;
  assign bus.instr          = instr_q;
  assign bus.instr_pc       = 32'(pc_q);
  assign unused_redirect_hi = ^bus.redirect_pc[31:AW];
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= FETCH;
      pc_q        <= AW'(RESET_PC);
      issue_idx_q <= '0;
      cap_en_q    <= 1'b0;
      cap_idx_q   <= '0;
      instr_q     <= '0;
    end else if (bus.redirect_valid) begin
      state_q     <= FETCH;
      pc_q        <= {bus.redirect_pc[AW-1:2], 2'b00};
      issue_idx_q <= '0;
      cap_en_q    <= 1'b0;
      cap_idx_q   <= '0;
    end else if (bus.instr_valid && bus.instr_ready) begin
      state_q     <= FETCH;
      pc_q        <= pc_q + AW'(4);
      issue_idx_q <= '0;
      cap_en_q    <= 1'b0;
      cap_idx_q   <= '0;
    end else if (state_q == FETCH) begin
      cap_en_q <= issue_idx_q != 3'd4;
      if (issue_idx_q != 3'd4) issue_idx_q <= issue_idx_q + 3'd1;
      if (cap_en_q) begin
        instr_q[8*cap_idx_q +: 8] <= bus.mem_data;
        cap_idx_q                 <= cap_idx_q + 2'd1;
        if (cap_idx_q == 2'd3) state_q <= HOLD;
      end
    end
  end
endmodule

// File: tb/tb_inst_fetch_assembler.sv
// tb_inst_fetch_assembler: byte memory model plus a queue of expected (pc, instr)
// pairs that is drained as the DUT presents instructions.
module tb_inst_fetch_assembler;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] mem [32];
  logic [63:0] exp_q [$];
  int tests = 0;
  int fails = 0;

  inst_fetch_assembler_if bus ();

  inst_fetch_assembler #(.MEM_BYTES(32), .RESET_PC(0)) dut (
    .clock_i (clk),
    .reset_ni(rst_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.mem_data <= mem[bus.mem_addr[4:0]];

  function automatic logic [31:0] model(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (bus.instr_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    int n;
    logic [63:0] e;
    rst_n = 1'b0;
    bus.instr_ready = 1'b0;
    bus.redirect_valid = 1'b0;
    step();
    step();
    tests++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", bus.instr_valid); end
    tests++; if (bus.mem_addr !== 32'h0) begin fails++; $display("FAIL rst_mem_addr got %h want 0", bus.mem_addr); end
    tests++; if (bus.instr !== 32'h0) begin fails++; $display("FAIL rst_instr got %h want 0", bus.instr); end
    tests++; if (bus.instr_pc !== 32'h0) begin fails++; $display("FAIL rst_instr_pc got %h want 0", bus.instr_pc); end
    rst_n = 1'b1;
    exp_q.push_back({32'h0, 32'h00208b33});
    wait_valid(10, n);
    tests++; if (n !== 5) begin fails++; $display("FAIL reset_latency got %0d want 5", n); end
    if (exp_q.size() == 0) begin tests++; fails++; $display("FAIL reset_pop queue empty"); end
    else begin
      e = exp_q.pop_front();
      tests++; if (bus.instr !== e[31:0]) begin fails++; $display("FAIL reset_instr got %h want %h", bus.instr, e[31:0]); end
      tests++; if (bus.instr_pc !== e[63:32]) begin fails++; $display("FAIL reset_pc got %h want %h", bus.instr_pc, e[63:32]); end
    end
    for (int i = 0; i < 10; i++) begin
      step();
      tests++;
      if ({bus.instr_valid, bus.instr, bus.instr_pc} !== {1'b1, 32'h00208b33, 32'h0}) begin
        fails++;
        $display("FAIL hold_stable cycle %0d got v=%b i=%h pc=%h want v=1 i=00208b33 pc=0", i, bus.instr_valid, bus.instr, bus.instr_pc);
      end
    end
  endtask

  task automatic test_stream();
    int last;
    logic [63:0] e;
    last = 0;
    bus.instr_ready = 1'b1;
    exp_q.push_back({32'h4, 32'h40418bb3});
    exp_q.push_back({32'h8, model(8)});
    for (int i = 1; i <= 12; i++) begin
      step();
      if (bus.instr_valid) begin
        tests++; if (i - last !== 6) begin fails++; $display("FAIL stream_gap got %0d want 6", i - last); end
        last = i;
        if (exp_q.size() == 0) begin tests++; fails++; $display("FAIL stream_pop queue empty"); end
        else begin
          e = exp_q.pop_front();
          tests++; if (bus.instr !== e[31:0]) begin fails++; $display("FAIL stream_instr got %h want %h", bus.instr, e[31:0]); end
          tests++; if (bus.instr_pc !== e[63:32]) begin fails++; $display("FAIL stream_pc got %h want %h", bus.instr_pc, e[63:32]); end
        end
      end
    end
    bus.instr_ready = 1'b0;
    tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL stream_left got %0d want 0", exp_q.size()); end
    tests++; if (last !== 12) begin fails++; $display("FAIL stream_last got %0d want 12", last); end
  endtask

  task automatic test_wrap();
    int n;
    logic [63:0] e;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'd28;
    #1;
    tests++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL wrap_redir_gate got %b want 0", bus.instr_valid); end
    step();
    bus.redirect_valid = 1'b0;
    exp_q.push_back({32'd28, 32'h0107e8b3});
    wait_valid(10, n);
    tests++; if (n !== 5) begin fails++; $display("FAIL wrap_latency got %0d want 5", n); end
    if (exp_q.size() == 0) begin tests++; fails++; $display("FAIL wrap_pop queue empty"); end
    else begin
      e = exp_q.pop_front();
      tests++; if (bus.instr !== e[31:0]) begin fails++; $display("FAIL wrap_instr got %h want %h", bus.instr, e[31:0]); end
      tests++; if (bus.instr_pc !== e[63:32]) begin fails++; $display("FAIL wrap_pc got %h want %h", bus.instr_pc, e[63:32]); end
    end
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    tests++; if (bus.instr_pc !== 32'h0) begin fails++; $display("FAIL wrap_next_pc got %h want 0", bus.instr_pc); end
    tests++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL wrap_valid_fall got %b want 0", bus.instr_valid); end
    for (int i = 0; i < 4; i++) begin
      tests++; if (bus.mem_addr !== 32'(i)) begin fails++; $display("FAIL wrap_mem_addr got %h want %h", bus.mem_addr, i); end
      if (i < 3) step();
    end
  endtask

  task automatic test_redirect_mid();
    int n;
    logic [63:0] e;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0;
    step();
    bus.redirect_valid = 1'b0;
    step();
    step();
    step();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0E;
    #1;
    tests++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b want 0", bus.instr_valid); end
    step();
    bus.redirect_valid = 1'b0;
    exp_q.push_back({32'h0C, 32'h0083ccb3});
    wait_valid(10, n);
    tests++; if (n !== 5) begin fails++; $display("FAIL mid_latency got %0d want 5", n); end
    if (exp_q.size() == 0) begin tests++; fails++; $display("FAIL mid_pop queue empty"); end
    else begin
      e = exp_q.pop_front();
      tests++; if (bus.instr !== e[31:0]) begin fails++; $display("FAIL mid_instr got %h want %h", bus.instr, e[31:0]); end
      tests++; if (bus.instr_pc !== e[63:32]) begin fails++; $display("FAIL mid_pc got %h want %h", bus.instr_pc, e[63:32]); end
    end
  endtask

  task automatic test_redirect_vs_ready();
    int n;
    logic [63:0] e;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h34;
    bus.instr_ready = 1'b1;
    #1;
    tests++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL rvr_gate got %b want 0", bus.instr_valid); end
    step();
    bus.redirect_valid = 1'b0;
    tests++; if (bus.instr_pc !== 32'h14) begin fails++; $display("FAIL rvr_pc got %h want 14", bus.instr_pc); end
    tests++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL rvr_valid got %b want 0", bus.instr_valid); end
    exp_q.push_back({32'h14, model(20)});
    wait_valid(10, n);
    bus.instr_ready = 1'b0;
    tests++; if (n !== 5) begin fails++; $display("FAIL rvr_latency got %0d want 5", n); end
    if (exp_q.size() == 0) begin tests++; fails++; $display("FAIL rvr_pop queue empty"); end
    else begin
      e = exp_q.pop_front();
      tests++; if (bus.instr !== e[31:0]) begin fails++; $display("FAIL rvr_instr got %h want %h", bus.instr, e[31:0]); end
      tests++; if (bus.instr_pc !== e[63:32]) begin fails++; $display("FAIL rvr_instr_pc got %h want %h", bus.instr_pc, e[63:32]); end
    end
  endtask

  task automatic test_async_reset();
    int n;
    logic [63:0] e;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h8;
    step();
    bus.redirect_valid = 1'b0;
    step();
    step();
    tests++; if (bus.mem_addr !== 32'hA) begin fails++; $display("FAIL ar_pre_addr got %h want a", bus.mem_addr); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (bus.instr_valid !== 1'b0) begin fails++; $display("FAIL ar_valid got %b want 0", bus.instr_valid); end
    tests++; if (bus.mem_addr !== 32'h0) begin fails++; $display("FAIL ar_mem_addr got %h want 0", bus.mem_addr); end
    tests++; if (bus.instr_pc !== 32'h0) begin fails++; $display("FAIL ar_instr_pc got %h want 0", bus.instr_pc); end
    step();
    rst_n = 1'b1;
    exp_q.push_back({32'h0, 32'h00208b33});
    wait_valid(10, n);
    tests++; if (n !== 5) begin fails++; $display("FAIL ar_latency got %0d want 5", n); end
    if (exp_q.size() == 0) begin tests++; fails++; $display("FAIL ar_pop queue empty"); end
    else begin
      e = exp_q.pop_front();
      tests++; if (bus.instr !== e[31:0]) begin fails++; $display("FAIL ar_instr got %h want %h", bus.instr, e[31:0]); end
      tests++; if (bus.instr_pc !== e[63:32]) begin fails++; $display("FAIL ar_pc got %h want %h", bus.instr_pc, e[63:32]); end
    end
    tests++; if (exp_q.size() !== 0) begin fails++; $display("FAIL final_left got %0d want 0", exp_q.size()); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
    {mem[3], mem[2], mem[1], mem[0]} = 32'h00208b33;
    {mem[7], mem[6], mem[5], mem[4]} = 32'h40418bb3;
    {mem[11], mem[10], mem[9], mem[8]} = 32'h00c58533;
    {mem[15], mem[14], mem[13], mem[12]} = 32'h0083ccb3;
    {mem[31], mem[30], mem[29], mem[28]} = 32'h0107e8b3;
    bus.mem_data = 8'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_wrap();
    test_redirect_mid();
    test_redirect_vs_ready();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/inst_fetch_assembler.md
# inst_fetch_assembler

Fetch stage sitting directly in front of the byte-wide instruction memory. It drives the memory's byte address, collects the four bytes returned one per cycle (one-cycle read latency), assembles them little-endian into a 32-bit instruction, and presents that instruction to the decoder over a valid/ready handshake. It also owns the program counter, covering sequential advance, wrap-around and redirect.

## Interface
- `MEM_BYTES`, default 32: instruction memory size in bytes. Power of two, at least 4.
- `RESET_PC`, default 0: PC loaded on reset. Multiple of 4, less than MEM_BYTES.

- `clock`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: asynchronous, active-low. 0 resets all state immediately; release is synchronous to `clock`.
- `mem_addr`  out  32: byte address to instruction memory (its PC input).
- `mem_data`  in  8: byte returned by memory; reflects the `mem_addr` sampled at the previous rising edge.
- `redirect_valid`  in  1: load a new PC (branch/jump).
- `redirect_pc`  in  32: target byte address.
- `instr_valid`  out  1: `instr` and `instr_pc` hold a complete instruction.
- `instr_ready`  in  1: decoder accepts the instruction.
- `instr`  out  32: assembled instruction. Byte at pc+0 goes to [7:0]; byte at pc+3 goes to [31:24].
- `instr_pc`  out  32: address of byte 0 of `instr`.

## Operation
- **State:**
  - `pc`: log2(MEM_BYTES) bits, zero-extended on outputs.
  - FSM: FETCH or HOLD.
  - `issue_idx`: 0..4.
  - `cap_en`: 1 bit, registered.
  - `cap_idx`: 0..3.
  - `instr` register.
- **Reset values:**
  - `pc = RESET_PC`, FSM = FETCH, `issue_idx = 0`, `cap_en = 0`, `cap_idx = 0`.
  - Outputs: `instr = 0`, `instr_valid = 0`, `instr_pc = RESET_PC`, `mem_addr = RESET_PC`.
- **`mem_addr`:**
  - Combinational: `pc + min(issue_idx, 3)`.
  - Never exceeds MEM_BYTES-1, because `pc` is 4-aligned.
- **FETCH:**
  - Each edge with `issue_idx < 4`: `issue_idx` increments.
  - `cap_en` is registered each edge as (FETCH and `issue_idx < 4`).
  - Each edge with `cap_en = 1`: `instr[8*cap_idx +: 8] <= mem_data`, then `cap_idx` increments.
  - The edge that captures `cap_idx = 3` moves the FSM to HOLD.
- **HOLD:**
  - `instr` and `instr_pc` are stable; no memory issue.
  - `instr_valid = (FSM == HOLD) && !redirect_valid`. This is a combinational gate.
- **Transfer** (`instr_valid && instr_ready` at an edge):
  - `pc <= (pc + 4) mod MEM_BYTES`.
  - FSM goes to FETCH; `issue_idx`, `cap_idx` and `cap_en` clear.
- **Redirect** (`redirect_valid` at an edge, any state):
  - `pc <= redirect_pc mod MEM_BYTES` with bits [1:0] forced to 0.
  - FSM goes to FETCH; counters and `cap_en` clear.
  - Any partially assembled bytes are discarded.
  - Redirect has priority over transfer. Because `instr_valid` is gated low during redirect, no transfer can coincide with it.
- `instr_pc` follows `pc`.
- `instr` bits are not cleared between fetches. `instr` is only meaningful while `instr_valid` is high.
- **Wrap-around:** `pc = MEM_BYTES-4` advances to 0.

## Timing
- **Fetch latency:** from the edge that enters FETCH (reset release, transfer, or redirect), bytes 0..3 are issued at edges 1..4 and captured at edges 2..5. `instr_valid` rises after edge 5.
- **Throughput:** at most one instruction per 6 cycles, when `instr_ready` is held at 1. Fetches do not overlap.
- **`instr_valid` after transfer/redirect:** falls in the cycle following the transfer or redirect edge. It stays high indefinitely while `instr_ready = 0`.
- **Reset mid-fetch:** all state clears asynchronously. The fetch restarts at `RESET_PC`, with byte 0 issued at the first edge after release.
- **Redirect while in FETCH:** restarts the 5-edge sequence from the redirect edge. No byte from the old address lands in the new `instr`.

## Test plan
- **Reset fetch:** memory bytes 0..3 = 33,8b,20,00; release reset and hold `instr_ready = 0` -> `instr_valid` rises after edge 5 with `instr = 0x00208b33`, `instr_pc = 0`. Values stay stable for 10 further cycles.
- **Sequential stream:** `instr_ready = 1`; memory holds 0x00208b33 at byte 0 and 0x40418bb3 at byte 4 -> each instruction valid for exactly one cycle, 6 cycles apart. `instr_pc` sequence is 0, 4, 8.
- **Wrap:** MEM_BYTES = 32; accept instruction at pc 28 (0x0107e8b3) -> next `instr_pc = 0`, and `mem_addr` sequence is 0,1,2,3.
- **Redirect mid-fetch:** assert `redirect_valid` with `redirect_pc = 0x0E` while the fetch at pc 0 is at `cap_idx = 2` -> the `instr_pc = 0` instruction is never valid. Next valid has `instr_pc = 0x0C`, `instr = 0x0083ccb3`, 5 edges after redirect.
- **Redirect vs ready:** in HOLD, assert `redirect_valid` and `instr_ready` together -> `instr_valid` is 0 in that cycle, `pc` takes the redirect target, and the old instruction is not re-presented.
- **Async reset mid-fetch:** pull `reset` low between edges during FETCH -> `instr_valid = 0` and `mem_addr = RESET_PC` without waiting for a clock edge. A fresh fetch completes 5 edges after release.
